truth_table_sweeper: RTL and testbench

- Synthesizable, parametrised exhaustive-sweep checker for combinational lab blocks.
- On `start`, drives every input combination 0 .. 2^N_IN-1 onto a DUT.
- After a programmable settle time, samples each DUT output and compares it against a golden truth table supplied as a flat vector.
- Reports a pass flag, a mismatch count and the first failing index. It replaces hand-written per-vector stimulus lists with an on-board self-check.

---
 rtl/truth_table_sweeper.sv | 109 ++++++++++
 tb/tb_truth_table_sweeper.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: walks every input combination of a combinational
// block, compares its outputs to a golden table and reports pass/err_count/first failure.
module truth_table_sweeper #(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned N_OUT  = 1,
    parameter int unsigned SETTLE = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [N_OUT*(2**N_IN)-1:0]   expected_tbl,
    output logic [N_IN-1:0]              dut_in,
    input  logic [N_OUT-1:0]             dut_out,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [N_IN:0]                err_count,
    output logic [N_IN-1:0]              first_err_idx,
    output logic                         first_err_valid
);

    localparam int unsigned N_VEC = 2**N_IN;
    localparam int unsigned CW    = N_IN + 1;
    localparam int unsigned SW    = 4;
    localparam logic [N_IN-1:0] LAST_IDX    = N_IN'(N_VEC - 1);
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state;
    logic [SW-1:0]   settle;
    logic            last_q;
    logic [N_OUT-1:0] expected_c;
    logic            mismatch_c;

    // Golden slice for the vector currently on dut_in.
    assign expected_c = expected_tbl[32'(dut_in) * N_OUT +: N_OUT];
    assign mismatch_c = (dut_out != expected_c);

    // last_q adds one closing cycle after the final compare so the result is settled
    // before done rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            settle          <= '0;
            last_q          <= 1'b0;
            dut_in          <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_idx   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state           <= DRIVE;
                        settle          <= '0;
                        last_q          <= 1'b0;
                        dut_in          <= '0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        err_count       <= '0;
                        first_err_idx   <= '0;
                        first_err_valid <= 1'b0;
                    end
                end
                DRIVE: begin
                    settle <= settle + SW'(1);
                    if (settle == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (last_q) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0);
                    end else begin
                        if (mismatch_c) begin
                            err_count <= err_count + CW'(1);
                            if (!first_err_valid) begin
                                first_err_idx   <= dut_in;
                                first_err_valid <= 1'b1;
                            end
                        end
                        if (dut_in == LAST_IDX) begin
                            last_q <= 1'b1;
                        end else begin
                            dut_in <= dut_in + N_IN'(1);
                            settle <= '0;
                            state  <= DRIVE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a 3-input/1-output/SETTLE=1 instance and a
// 4-input/2-output/SETTLE=3 instance, vector table plus random tables vs a reference loop.
module tb_truth_table_sweeper;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // Small instance: DUT is a lookup of map3, golden table is tbl3.
    logic       start3 = 1'b0;
    logic [7:0] tbl3   = 8'h96;
    logic [7:0] map3   = 8'h96;
    logic [2:0] din3;
    logic       dout3;
    logic       busy3, done3, pass3, fv3;
    logic [3:0] err3;
    logic [2:0] fidx3;
    assign dout3 = map3[din3];

    truth_table_sweeper #(.N_IN(3), .N_OUT(1), .SETTLE(1)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .expected_tbl(tbl3),
        .dut_in(din3), .dut_out(dout3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .first_err_idx(fidx3), .first_err_valid(fv3)
    );

    // Wide instance: DUT is {A&B, C|D} with an optional bit-0 flip at index 10.
    logic        start4 = 1'b0;
    logic [31:0] tbl4;
    logic        inject = 1'b1;
    logic [3:0]  din4;
    logic [1:0]  dout4;
    logic        busy4, done4, pass4, fv4;
    logic [4:0]  err4;
    logic [3:0]  fidx4;

    function automatic logic [1:0] gate4(input logic [3:0] v);
        return {v[0] & v[1], v[2] | v[3]};
    endfunction
    assign dout4 = gate4(din4) ^ ((inject && din4 == 4'd10) ? 2'b01 : 2'b00);

    truth_table_sweeper #(.N_IN(4), .N_OUT(2), .SETTLE(3)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .expected_tbl(tbl4),
        .dut_in(din4), .dut_out(dout4), .busy(busy4), .done(done4), .pass(pass4),
        .err_count(err4), .first_err_idx(fidx4), .first_err_valid(fv4)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Pulses start3; tracks cycles after the start edge until done and checks dut_in/busy each cycle.
    task automatic run3(input bit mid_start, output int dcyc, output bit seq_ok);
        int e_idx;
        seq_ok = 1'b1;
        dcyc   = -1;
        @(posedge clk); #1 start3 = 1'b1;
        @(posedge clk); #1 start3 = 1'b0;
        for (int c = 0; c <= 100; c++) begin
            if (done3 === 1'b1) begin
                dcyc = c;
                if (din3 !== 3'd7 || busy3 !== 1'b0) seq_ok = 1'b0;
                break;
            end
            e_idx = (c / 2 > 7) ? 7 : c / 2;
            if (din3 !== 3'(e_idx) || busy3 !== 1'b1) seq_ok = 1'b0;
            start3 = (mid_start && c == 5);
            @(posedge clk); #1;
        end
        start3 = 1'b0;
    endtask

    task automatic check3(input string tag, input int dcyc, input bit seq_ok,
                          input int e_err, input int e_first);
        chk({tag, " done_cycle"}, dcyc, 17);
        chk({tag, " dut_in_seq"}, int'(seq_ok), 1);
        chk({tag, " pass"}, int'(pass3), int'(e_err == 0));
        chk({tag, " err_count"}, int'(err3), e_err);
        chk({tag, " first_err_idx"}, int'(fidx3), e_first);
        chk({tag, " first_err_valid"}, int'(fv3), int'(e_err != 0));
    endtask

    task automatic run4(input string tag, output int dcyc, output bit seq_ok);
        int e_idx;
        seq_ok = 1'b1;
        dcyc   = -1;
        @(posedge clk); #1 start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        chk({tag, " start_edge_done"}, int'(done4), 0);
        chk({tag, " start_edge_err"}, int'(err4), 0);
        chk({tag, " start_edge_fv"}, int'(fv4), 0);
        for (int c = 0; c <= 200; c++) begin
            if (done4 === 1'b1) begin
                dcyc = c;
                if (din4 !== 4'd15 || busy4 !== 1'b0) seq_ok = 1'b0;
                break;
            end
            e_idx = (c / 4 > 15) ? 15 : c / 4;
            if (din4 !== 4'(e_idx) || busy4 !== 1'b1) seq_ok = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        string      name;
        logic [7:0] tbl;
        logic [7:0] map;
        int         e_err;
        int         e_first;
        bit         mid;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int  dcyc, e_err, e_first;
        bit  seq_ok, found;

        vecs[0] = '{"xor_clean",   8'h96, 8'h96, 0, 0, 1'b0};
        vecs[1] = '{"stuck0",      8'h96, 8'h00, 4, 1, 1'b0};
        vecs[2] = '{"mid_start",   8'h96, 8'h96, 0, 0, 1'b1};
        vecs[3] = '{"idx0_only",   8'h96, 8'h97, 1, 0, 1'b0};
        vecs[4] = '{"last_vector", 8'h96, 8'h16, 1, 7, 1'b0};
        vecs[5] = '{"all_wrong",   8'h96, 8'h69, 8, 0, 1'b0};

        for (int i = 0; i < 16; i++) tbl4[i*2 +: 2] = gate4(4'(i));

        // Asynchronous reset: values must appear before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("reset busy", int'(busy3), 0);
        chk("reset done", int'(done3), 0);
        chk("reset dut_in", int'(din3), 0);
        chk("reset err_count", int'(err3), 0);
        chk("reset pass", int'(pass3), 0);
        chk("reset fv", int'(fv3), 0);
        chk("reset busy4", int'(busy4), 0);
        @(negedge clk) rst_n = 1'b1;

        foreach (vecs[i]) begin
            tbl3 = vecs[i].tbl;
            map3 = vecs[i].map;
            run3(vecs[i].mid, dcyc, seq_ok);
            check3(vecs[i].name, dcyc, seq_ok, vecs[i].e_err, vecs[i].e_first);
        end

        // Random golden tables and random DUT behaviour against a reference count.
        for (int r = 0; r < 6; r++) begin
            tbl3 = 8'($urandom);
            map3 = 8'($urandom);
            e_err = 0; e_first = 0; found = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (tbl3[i] != map3[i]) begin
                    e_err++;
                    if (!found) e_first = i;
                    found = 1'b1;
                end
            end
            run3(1'b0, dcyc, seq_ok);
            check3($sformatf("random%0d", r), dcyc, seq_ok, e_err, e_first);
        end

        // Async reset during SAMPLE of idx 5 aborts the sweep at once.
        tbl3 = 8'h96;
        map3 = 8'h00;
        @(posedge clk); #1 start3 = 1'b1;
        @(posedge clk); #1 start3 = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        chk("pre_reset dut_in", int'(din3), 5);
        chk("pre_reset err_count", int'(err3), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset busy", int'(busy3), 0);
        chk("mid_reset dut_in", int'(din3), 0);
        chk("mid_reset err_count", int'(err3), 0);
        chk("mid_reset fv", int'(fv3), 0);
        @(negedge clk) rst_n = 1'b1;
        map3 = 8'h96;
        run3(1'b0, dcyc, seq_ok);
        check3("after_reset", dcyc, seq_ok, 0, 0);

        // Wide instance: single injected error, then restart from DONE with it removed.
        for (int pass_no = 0; pass_no < 2; pass_no++) begin
            inject = (pass_no == 0);
            e_err = 0; e_first = 0; found = 1'b0;
            for (int i = 0; i < 16; i++) begin
                logic [1:0] resp;
                resp = gate4(4'(i)) ^ ((inject && i == 10) ? 2'b01 : 2'b00);
                if (resp != tbl4[i*2 +: 2]) begin
                    e_err++;
                    if (!found) e_first = i;
                    found = 1'b1;
                end
            end
            run4($sformatf("wide%0d", pass_no), dcyc, seq_ok);
            chk("wide done_cycle", dcyc, 65);
            chk("wide dut_in_seq", int'(seq_ok), 1);
            chk("wide err_count", int'(err4), e_err);
            chk("wide first_err_idx", int'(fidx4), e_first);
            chk("wide first_err_valid", int'(fv4), int'(e_err != 0));
            chk("wide pass", int'(pass4), int'(e_err == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
